// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-capped arbiter for the async FIFO write port
module fifo_wr_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NREQ      = 4,
    parameter int IDXWIDTH  = 2,
    parameter int MAX_BURST = 8,
    parameter int CNTWIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           I_req,
    input  logic [NREQ*DATAWIDTH-1:0] I_data,
    input  logic                      I_en,
    input  logic                      I_full,
    output logic [NREQ-1:0]           O_gnt,
    output logic                      O_wren,
    output logic [DATAWIDTH-1:0]      O_data_out,
    output logic [IDXWIDTH-1:0]       O_owner,
    output logic                      O_busy
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_n;
    logic [IDXWIDTH-1:0]   owner, owner_n, last, last_n, pick, pick_hi, pick_lo;
    logic [CNTWIDTH-1:0]   cnt, cnt_n;
    logic                  found_hi, xfer;
    logic [DATAWIDTH-1:0]  words [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            words[i] = I_data[i*DATAWIDTH +: DATAWIDTH];
        end
    end

    // Lowest requester above last wins; otherwise wrap to the lowest one at or below it.
    always_comb begin
        found_hi = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (I_req[i]) begin
                if (IDXWIDTH'(i) > last) begin
                    found_hi = 1'b1;
                    pick_hi  = IDXWIDTH'(i);
                end else begin
                    pick_lo  = IDXWIDTH'(i);
                end
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    assign xfer = (state == BURST) && I_req[owner] && !I_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= '0;
            cnt   <= '0;
            last  <= IDXWIDTH'(NREQ - 1);
        end else begin
            state <= state_n;
            owner <= owner_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        cnt_n   = cnt;
        last_n  = last;
        case (state)
            IDLE: begin
                if (I_en && |I_req) begin
                    state_n = BURST;
                    owner_n = pick;
                    cnt_n   = '0;
                end
            end
            BURST: begin
                if (!I_req[owner]) begin
                    state_n = IDLE;
                    last_n  = owner;
                end else if (!I_full) begin
                    cnt_n = cnt + 1'b1;
                    if (cnt_n == CNTWIDTH'(MAX_BURST)) begin
                        state_n = IDLE;
                        last_n  = owner;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are combinational so a full flag blocks the write in the same cycle.
    always_comb begin
        O_gnt      = '0;
        O_busy     = (state == BURST);
        O_wren     = xfer;
        O_data_out = '0;
        if ((state == BURST) && !I_full) begin
            O_gnt[owner] = 1'b1;
        end
        if (xfer) begin
            O_data_out = words[owner];
        end
    end

    assign O_owner = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - cycle-exact scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    logic        clk, rst, en, full;
    logic [3:0]  req;
    logic [31:0] data_bus;
    logic [3:0]  gnt;
    logic        wren, busy;
    logic [7:0]  data_out;
    logic [1:0]  owner;

    typedef struct packed {
        logic       w;
        logic [1:0] o;
        logic       b;
        logic       f;
        logic [7:0] d;
    } exp_t;

    exp_t       sb [$];
    logic [5:0] seq     [4];
    logic [5:0] exp_seq [4];
    int         n_cmp, n_err;

    fifo_wr_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .I_req      (req),
        .I_data     (data_bus),
        .I_en       (en),
        .I_full     (full),
        .O_gnt      (gnt),
        .O_wren     (wren),
        .O_data_out (data_out),
        .O_owner    (owner),
        .O_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mkdata(input int i, input logic [5:0] s);
        return 8'(i * 64) + {2'b00, s};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Requester model: each source advances its word when the handshake completes.
    always_comb begin
        for (int i = 0; i < 4; i++) data_bus[i*8 +: 8] = mkdata(i, seq[i]);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (req[i] && gnt[i]) seq[i] <= seq[i] + 6'd1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_val("wren",  32'(wren),     32'(e.w));
            check_val("owner", 32'(owner),    32'(e.o));
            check_val("busy",  32'(busy),     32'(e.b));
            check_val("gnt",   32'(gnt),      (e.b && !e.f) ? (32'd1 << e.o) : 32'd0);
            check_val("data",  32'(data_out), 32'(e.d));
        end
    end

    task automatic push_exp(input logic w, input logic [1:0] o, input logic b);
        exp_t e;
        e.w = w; e.o = o; e.b = b; e.f = full;
        e.d = w ? mkdata(int'(o), exp_seq[o]) : 8'h00;
        if (w) exp_seq[o] = exp_seq[o] + 6'd1;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [3:0] r, input logic e, input logic f,
                       input logic w, input logic [1:0] o, input logic b);
        @(posedge clk);
        #1;
        req = r; en = e; full = f;
        push_exp(w, o, b);
    endtask

    task automatic idle(input logic [3:0] r, input logic e, input logic [1:0] o);
        cyc(r, e, 1'b0, 1'b0, o, 1'b0);
    endtask

    task automatic writes(input logic [3:0] r, input logic e, input int n, input logic [1:0] o);
        repeat (n) cyc(r, e, 1'b0, 1'b1, o, 1'b1);
    endtask

    task automatic burst(input logic [3:0] r, input logic [1:0] prev, input logic [1:0] o);
        idle(r, 1'b1, prev);
        writes(r, 1'b1, 8, o);
    endtask

    task automatic reset_outputs(input string pfx);
        check_val({pfx, "_wren"},  32'(wren),     32'd0);
        check_val({pfx, "_gnt"},   32'(gnt),      32'd0);
        check_val({pfx, "_busy"},  32'(busy),     32'd0);
        check_val({pfx, "_owner"}, 32'(owner),    32'd0);
        check_val({pfx, "_data"},  32'(data_out), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; req = 4'b0000; en = 1'b1; full = 1'b0;
        #1;
        reset_outputs("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0; n_err = 0;
        for (int i = 0; i < 4; i++) begin seq[i] = '0; exp_seq[i] = '0; end
        rst = 1'b1; req = '0; en = 1'b0; full = 1'b0;

        // single requester, bursts capped at 8 with one bubble
        do_reset();
        burst(4'b0001, 2'd0, 2'd0);
        burst(4'b0001, 2'd0, 2'd0);
        idle(4'b0000, 1'b1, 2'd0);

        // all requesting: owners 0,1,2,3,0
        do_reset();
        burst(4'b1111, 2'd0, 2'd0);
        burst(4'b1111, 2'd0, 2'd1);
        burst(4'b1111, 2'd1, 2'd2);
        burst(4'b1111, 2'd2, 2'd3);
        burst(4'b1111, 2'd3, 2'd0);
        idle(4'b0000, 1'b1, 2'd0);

        // full stall after 3 writes
        do_reset();
        idle(4'b0001, 1'b1, 2'd0);
        writes(4'b0001, 1'b1, 3, 2'd0);
        repeat (5) cyc(4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        writes(4'b0001, 1'b1, 5, 2'd0);
        idle(4'b0000, 1'b1, 2'd0);

        // early release by 2 hands over to 3, not 0
        do_reset();
        idle(4'b1100, 1'b1, 2'd0);
        writes(4'b1100, 1'b1, 2, 2'd2);
        cyc(4'b1000, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1);
        idle(4'b1001, 1'b1, 2'd2);
        writes(4'b1001, 1'b1, 8, 2'd3);
        idle(4'b0000, 1'b1, 2'd3);

        // enable gating; dropping enable mid-burst does not abort it
        do_reset();
        repeat (3) idle(4'b0100, 1'b0, 2'd0);
        idle(4'b0100, 1'b1, 2'd0);
        writes(4'b0100, 1'b1, 2, 2'd2);
        writes(4'b0100, 1'b0, 6, 2'd2);
        idle(4'b0100, 1'b0, 2'd2);
        idle(4'b0100, 1'b0, 2'd2);
        idle(4'b0000, 1'b0, 2'd2);

        // asynchronous reset in the middle of a burst
        do_reset();
        idle(4'b1111, 1'b1, 2'd0);
        writes(4'b1111, 1'b1, 3, 2'd0);
        @(posedge clk);
        #2;
        check_val("pre_rst_wren", 32'(wren), 32'd1);
        rst = 1'b1;
        #1;
        reset_outputs("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(1'b0, 2'd0, 1'b0);
        writes(4'b1111, 1'b1, 8, 2'd0);
        idle(4'b0000, 1'b1, 2'd0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of the team's async FIFO among NREQ requesters in the FIFO's write clock domain.
- Grants one requester at a time using round-robin order, with bursts capped at MAX_BURST words.
- Stalls on FIFO full, and drives the FIFO's write enable and data input directly.

Parameters:
- DATAWIDTH, 8, word width; matches the FIFO DATAWIDTH.
- NREQ, 4, number of requesters (2..16).
- IDXWIDTH, 2, width of the owner index; must satisfy 2^IDXWIDTH >= NREQ.
- MAX_BURST, 8, maximum words per grant (1..2^CNTWIDTH-1).
- CNTWIDTH, 4, width of the burst counter.

Ports:
- clk  input  1  single clock; the FIFO write clock.
- rst  input  1  asynchronous, active-high reset.
- I_req  input  NREQ  bit i high: requester i has a valid word on its data slice.
- I_data  input  NREQ*DATAWIDTH  requester i word on bits [i*DATAWIDTH +: DATAWIDTH].
- I_en  input  1  arbitration enable; low blocks new grants.
- I_full  input  1  FIFO full flag.
- O_gnt  output  NREQ  one-hot ready; the word transfers in any cycle where I_req[i] && O_gnt[i].
- O_wren  output  1  to FIFO I_wren.
- O_data_out  output  DATAWIDTH  to FIFO I_data_in.
- O_owner  output  IDXWIDTH  index of the current or last owner.
- O_busy  output  1  high while in BURST.

Behaviour:
- Decided: one clock (clk); reset asynchronous and active-high (rst).
- Registered state: state (IDLE/BURST), owner, burst count cnt, and last (round-robin pointer).
- Reset values: state=IDLE, cnt=0, owner=0, last=NREQ-1 (so requester 0 has top priority first).
- Output values in reset: O_gnt=0, O_wren=0, O_busy=0, O_owner=0, O_data_out=0.
- Combinational outputs:
  - O_gnt[i] = (state==BURST) && (owner==i) && !I_full.
  - O_wren = (state==BURST) && I_req[owner] && !I_full.
  - O_data_out = I_data slice[owner] when O_wren=1, else 0.
  - Zero latency from requester to FIFO; no extra pipeline stage, so I_full is honoured in the same cycle.
- IDLE:
  - If I_en=1 and any I_req is set, choose the first set bit searching from (last+1) mod NREQ upward with wrap.
  - Load owner with that index, set cnt=0, and go to BURST next cycle.
  - Otherwise stay in IDLE.
  - Arbitration costs 1 cycle: the first word transfers no earlier than the cycle after the request is seen.
- BURST, transfer cycle (O_wren=1): cnt increments.
  - If cnt+1==MAX_BURST, go to IDLE and set last=owner.
- BURST, exit on dropped request: if I_req[owner]=0, go to IDLE with last=owner and no transfer. Dropping the request ends the burst.
- BURST, stall: if I_full=1 and I_req[owner]=1, hold; cnt frozen, no transfer, no timeout.
- I_en deasserted during BURST does not abort the burst; it only blocks the next grant from IDLE.
- There is always one IDLE bubble between consecutive bursts (including the same requester re-winning); sustained throughput is MAX_BURST/(MAX_BURST+1).
- Requests from non-owners are ignored until the next IDLE; no requester may be granted twice while another requester with a pending request is skipped (fairness).
- O_owner = owner register; it holds its value in IDLE.
- Reset mid-burst: return immediately to reset values. A word is never written during reset; a partial burst is not resumed.
- Wrap-around: the search wraps from NREQ-1 to 0; cnt never exceeds MAX_BURST.

Test Plan:
- Single requester, burst cut by MAX_BURST:
  - Stimulus: rst release; I_req=0001 held; I_data slice0 counts 0x00,0x01,...; I_en=1, I_full=0.
  - Required: 1 idle cycle, then 8 consecutive O_wren with O_data_out 0x00..0x07, then 1 bubble, then the next burst starting at 0x08.
- Round-robin with all requesting:
  - Stimulus: I_req=1111 held, MAX_BURST=8.
  - Required: O_owner sequence 0,1,2,3,0; each burst exactly 8 writes; exactly 1 bubble between bursts.
- Full stall:
  - Stimulus: mid-burst after 3 writes, I_full=1 for 5 cycles, then 0.
  - Required: O_wren=0 and O_gnt=0 for those 5 cycles; cnt holds; 5 more writes complete the burst; 8 words total.
- Early release:
  - Stimulus: requester 2 owns the bus and drops I_req after 2 words while requester 3 is pending.
  - Required: burst ends with 2 writes; the next owner is 3, not 0.
- I_en gating:
  - Stimulus: I_en=0 with I_req=0100.
  - Required: stays IDLE, O_busy=0. Setting I_en=1 grants requester 2 the next cycle.
  - Stimulus: deassert I_en mid-burst. Required: the burst completes.
- Async reset mid-burst:
  - Stimulus: assert rst between clock edges during BURST.
  - Required: O_wren, O_gnt and O_busy go to 0 immediately, without waiting for an edge. After release with I_req=1111, the first owner is 0.
